// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM duty ramp scheduler.
// Holds the sweep FSM state encoding and default widths.
package pwm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        EMIT,
        NEXT
    } state_t;

    localparam int DUTY_W_DEF = 16;
    localparam int STEP_W     = 8;

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running tick divider: counts 0..TICK_DIV-1 while enabled and
// pulses tick_o for one cycle on wrap.
// Ports: clk_i, rst_ni (async low), en_i (run), tick_o (1-cycle pulse).
module pwm_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap   = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_o = en_i && wrap;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || wrap) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Ramps each channel's duty toward its target by at most `step` per tick,
// sharing one compare/add path and offering updates over valid/ready.
// Ports: ACLK/ARESETN, enable, step, tgt_we/tgt_ch/tgt_duty (target write),
// duty_valid/duty_ch/duty_value/duty_ready (update port), at_target,
// busy, overrun (sticky double-pending tick).
module pwm_ramp_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DUTY_W   = DUTY_W_DEF,
    parameter int TICK_DIV = 100000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      enable,
    input  logic [STEP_W-1:0]         step,
    input  logic                      tgt_we,
    input  logic [$clog2(NUM_CH)-1:0] tgt_ch,
    input  logic [DUTY_W-1:0]         tgt_duty,
    output logic                      duty_valid,
    output logic [$clog2(NUM_CH)-1:0] duty_ch,
    output logic [DUTY_W-1:0]         duty_value,
    input  logic                      duty_ready,
    output logic [NUM_CH-1:0]         at_target,
    output logic                      busy,
    output logic                      overrun
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic [CH_W-1:0]     dch_q;
    logic [DUTY_W-1:0]   dval_q;
    logic [DUTY_W-1:0]   cur_q [NUM_CH];
    logic [DUTY_W-1:0]   tgt_q [NUM_CH];

    logic                tick;
    logic                load;
    logic [DUTY_W-1:0]   cur_sel, tgt_sel, cur_new;
    logic [DUTY_W:0]     diff, absd, stepx, mag;

    pwm_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_i (ACLK),
        .rst_ni(ARESETN),
        .en_i  (enable),
        .tick_o(tick)
    );

    // Both operands are zero-extended, so bit DUTY_W of the
    // (DUTY_W+1)-bit difference is the sign of tgt - cur.
    assign cur_sel = cur_q[ch_q];
    assign tgt_sel = tgt_q[ch_q];
    assign diff    = {1'b0, tgt_sel} - {1'b0, cur_sel};
    assign absd    = diff[DUTY_W] ? (~diff + 1'b1) : diff;
    assign stepx   = {{(DUTY_W + 1 - STEP_W){1'b0}}, step};
    assign mag     = (stepx < absd) ? stepx : absd;
    assign cur_new = diff[DUTY_W] ? cur_sel - mag[DUTY_W-1:0]
                                  : cur_sel + mag[DUTY_W-1:0];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick || pend_q) begin
                    state_d = EVAL;
                    ch_d    = '0;
                    // a fresh tick landing with a pending one stays queued
                    pend_d  = pend_q && tick;
                end
            end
            EVAL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (diff == '0 || step == '0) begin
                    state_d = NEXT;
                end else begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (duty_ready) state_d = NEXT;
            end
            NEXT: begin
                if (!enable || ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = EVAL;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tick && state_q != IDLE) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
        end
        if (!enable) pend_d = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            dch_q   <= '0;
            dval_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            if (load) begin
                dch_q  <= ch_q;
                dval_q <= cur_new;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            if (tgt_we) tgt_q[tgt_ch] <= tgt_duty;
            if (load)   cur_q[ch_q]   <= cur_new;
        end
    end

    always_comb begin
        at_target = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            at_target[i] = (cur_q[i] == tgt_q[i]);
        end
    end

    assign duty_valid = (state_q == EMIT);
    assign duty_ch    = dch_q;
    assign duty_value = dval_q;
    assign busy       = (state_q != IDLE);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Directed bench for pwm_ramp_scheduler with a short tick divider.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_pwm_ramp_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  step = '0;
    logic        tgt_we = 1'b0;
    logic [1:0]  tgt_ch = '0;
    logic [15:0] tgt_duty = '0;
    logic        duty_valid;
    logic [1:0]  duty_ch;
    logic [15:0] duty_value;
    logic        duty_ready = 1'b1;
    logic [3:0]  at_target;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int em_ch[$];
    int em_val[$];

    pwm_ramp_scheduler #(
        .NUM_CH  (4),
        .DUTY_W  (16),
        .TICK_DIV(10)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .enable    (enable),
        .step      (step),
        .tgt_we    (tgt_we),
        .tgt_ch    (tgt_ch),
        .tgt_duty  (tgt_duty),
        .duty_valid(duty_valid),
        .duty_ch   (duty_ch),
        .duty_value(duty_value),
        .duty_ready(duty_ready),
        .at_target (at_target),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 ACLK = ~ACLK;

    // handshake is taken at the next rising edge
    always @(negedge ACLK) begin
        if (ARESETN && duty_valid && duty_ready) begin
            em_ch.push_back(int'(duty_ch));
            em_val.push_back(int'(duty_value));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic write_tgt(input int ch, input int val);
        tgt_we   = 1'b1;
        tgt_ch   = 2'(ch);
        tgt_duty = 16'(val);
        cyc(1);
        tgt_we   = 1'b0;
    endtask

    task automatic do_reset();
        ARESETN    = 1'b0;
        enable     = 1'b0;
        tgt_we     = 1'b0;
        duty_ready = 1'b1;
        cyc(3);
        ARESETN    = 1'b1;
        em_ch.delete();
        em_val.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (duty_valid !== 1'b0 || duty_ch !== 2'd0 || duty_value !== 16'd0) begin
            errors++;
            $display("FAIL reset_port: valid=%b ch=%0d val=%0d, want 0 0 0",
                     duty_valid, duty_ch, duty_value);
        end
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || at_target !== 4'hF) begin
            errors++;
            $display("FAIL reset_status: busy=%b ovr=%b at=%h, want 0 0 f",
                     busy, overrun, at_target);
        end
    endtask

    task automatic test_ramp_up();
        int exp_v[4] = '{10, 20, 30, 35};
        step = 8'd10;
        write_tgt(0, 35);
        checks++;
        if (at_target !== 4'b1110) begin
            errors++;
            $display("FAIL up_at_pre: got %b want 1110", at_target);
        end
        enable = 1'b1;
        cyc(70);
        checks++;
        if (em_val.size() != 4) begin
            errors++;
            $display("FAIL up_count: got %0d want 4", em_val.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= em_val.size() || em_ch[i] != 0 || em_val[i] != exp_v[i]) begin
                errors++;
                $display("FAIL up_emit%0d: got ch=%0d val=%0d want ch=0 val=%0d",
                         i, em_ch[i], em_val[i], exp_v[i]);
            end
        end
        checks++;
        if (at_target !== 4'hF) begin
            errors++;
            $display("FAIL up_at_post: got %h want f", at_target);
        end
    endtask

    task automatic test_ramp_down();
        int exp_v[3] = '{35, 19, 5};
        em_ch.delete();
        em_val.delete();
        step = 8'd40;
        write_tgt(1, 35);
        cyc(30);
        step = 8'd16;
        write_tgt(1, 5);
        cyc(40);
        checks++;
        if (em_val.size() != 3) begin
            errors++;
            $display("FAIL down_count: got %0d want 3", em_val.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= em_val.size() || em_ch[i] != 1 || em_val[i] != exp_v[i]) begin
                errors++;
                $display("FAIL down_emit%0d: got ch=%0d val=%0d want ch=1 val=%0d",
                         i, em_ch[i], em_val[i], exp_v[i]);
            end
        end
        checks++;
        if (at_target !== 4'hF) begin
            errors++;
            $display("FAIL down_at: got %h want f", at_target);
        end
    endtask

    task automatic test_backpressure();
        bit ok = 0;
        bit stable = 1;
        do_reset();
        duty_ready = 1'b0;
        step = 8'd4;
        for (int c = 0; c < 4; c++) write_tgt(c, 8);
        enable = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge ACLK);
            if (duty_valid) ok = 1;
        end
        checks++;
        if (!ok || duty_ch !== 2'd0 || duty_value !== 16'd4) begin
            errors++;
            $display("FAIL bp_first: ok=%0d ch=%0d val=%0d want 1 0 4",
                     ok, duty_ch, duty_value);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge ACLK);
            if (duty_valid !== 1'b1 || duty_ch !== 2'd0 || duty_value !== 16'd4)
                stable = 0;
            if (i == 12) begin
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_pending_no_ovr: got %b want 0", overrun);
                end
            end
            if (i == 22) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_overrun: got %b want 1", overrun);
                end
            end
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable: got 0 want 1");
        end
        @(posedge ACLK);
        #1;
        duty_ready = 1'b1;
        cyc(60);
        checks++;
        if (em_val.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d want 8", em_val.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= em_val.size() || em_ch[i] != (i % 4) ||
                em_val[i] != (i < 4 ? 4 : 8)) begin
                errors++;
                $display("FAIL bp_emit%0d: got ch=%0d val=%0d want ch=%0d val=%0d",
                         i, em_ch[i], em_val[i], i % 4, (i < 4 ? 4 : 8));
            end
        end
        checks++;
        if (at_target !== 4'hF || overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_end: at=%h ovr=%b want f 1", at_target, overrun);
        end
    endtask

    task automatic test_step_zero();
        do_reset();
        step = 8'd0;
        write_tgt(2, 100);
        enable = 1'b1;
        cyc(55);
        checks++;
        if (em_val.size() != 0 || at_target !== 4'b1011) begin
            errors++;
            $display("FAIL frozen: emits=%0d at=%b want 0 1011",
                     em_val.size(), at_target);
        end
        step = 8'd50;
        cyc(40);
        checks++;
        if (em_val.size() != 2) begin
            errors++;
            $display("FAIL thaw_count: got %0d want 2", em_val.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= em_val.size() || em_ch[i] != 2 || em_val[i] != 50 * (i + 1)) begin
                errors++;
                $display("FAIL thaw_emit%0d: got ch=%0d val=%0d want ch=2 val=%0d",
                         i, em_ch[i], em_val[i], 50 * (i + 1));
            end
        end
    endtask

    task automatic test_write_race();
        bit ok = 0;
        do_reset();
        step = 8'd50;
        enable = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge ACLK);
            if (busy) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL race_busy: got 0 want 1");
        end
        // busy first seen in EVAL ch0; EVAL ch2 is four cycles later
        @(posedge ACLK);
        #1;
        cyc(3);
        write_tgt(2, 30);
        cyc(4);
        checks++;
        if (em_val.size() != 0 || at_target !== 4'b1011) begin
            errors++;
            $display("FAIL race_old_tgt: emits=%0d at=%b want 0 1011",
                     em_val.size(), at_target);
        end
        cyc(20);
        checks++;
        if (em_val.size() != 1 || em_ch[0] != 2 || em_val[0] != 30) begin
            errors++;
            $display("FAIL race_new_tgt: n=%0d ch=%0d val=%0d want 1 2 30",
                     em_val.size(), em_ch[0], em_val[0]);
        end
    endtask

    task automatic test_reset_in_emit();
        bit ok = 0;
        do_reset();
        duty_ready = 1'b0;
        step = 8'd3;
        write_tgt(1, 7);
        enable = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge ACLK);
            if (duty_valid) ok = 1;
        end
        checks++;
        if (!ok || duty_ch !== 2'd1 || duty_value !== 16'd3) begin
            errors++;
            $display("FAIL rst_emit_pre: ok=%0d ch=%0d val=%0d want 1 1 3",
                     ok, duty_ch, duty_value);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if (duty_valid !== 1'b0 || duty_ch !== 2'd0 || duty_value !== 16'd0 ||
            busy !== 1'b0 || overrun !== 1'b0 || at_target !== 4'hF) begin
            errors++;
            $display("FAIL rst_async: v=%b ch=%0d val=%0d busy=%b ovr=%b at=%h want 0 0 0 0 0 f",
                     duty_valid, duty_ch, duty_value, busy, overrun, at_target);
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        duty_ready = 1'b1;
        cyc(40);
        checks++;
        if (em_val.size() != 0) begin
            errors++;
            $display("FAIL rst_quiet: emits=%0d want 0", em_val.size());
        end
        write_tgt(1, 6);
        cyc(40);
        checks++;
        if (em_val.size() != 2 || em_val[0] != 3 || em_val[1] != 6 ||
            em_ch[0] != 1 || em_ch[1] != 1) begin
            errors++;
            $display("FAIL rst_cur_zero: n=%0d v0=%0d v1=%0d want 2 3 6",
                     em_val.size(), em_val[0], em_val[1]);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_backpressure();
        test_step_zero();
        test_write_race();
        test_reset_in_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
